// File: rtl/decode_stage_pipe.sv
// Decode stage: instruction decode, condition check, register file with write-first
// bypass, and the ID/EX pipeline register feeding the execute stage.
module decode_stage_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_COUNT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [31:0]           instruction,
  input  logic [3:0]            status,
  input  logic                  wb_en,
  input  logic [3:0]            wb_dest,
  input  logic [WORD_WIDTH-1:0] wb_value,
  output logic                  two_src,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
  output logic                  ex_valid,
  output logic                  ex_wb_en,
  output logic                  ex_mem_r,
  output logic                  ex_mem_w,
  output logic                  ex_b,
  output logic                  ex_s,
  output logic                  ex_imm,
  output logic [3:0]            ex_exe_cmd,
  output logic [WORD_WIDTH-1:0] ex_pc,
  output logic [WORD_WIDTH-1:0] ex_val_rn,
  output logic [WORD_WIDTH-1:0] ex_val_rm,
  output logic [11:0]           ex_shift_op,
  output logic [23:0]           ex_imm24,
  output logic [3:0]            ex_dest,
  output logic [3:0]            ex_src1,
  output logic [3:0]            ex_src2
);

  localparam int ADDR_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic [WORD_WIDTH-1:0] regs_r [REG_COUNT];
  logic [WORD_WIDTH-1:0] val_rn_s, val_rm_s;
  logic [1:0] mode_s;
  logic [3:0] opcode_s, rd_s;
  logic       imm_s, sb_s, store_s;
  logic [3:0] cmd_s;
  logic       dec_wb_s, dec_mr_s, dec_mw_s, dec_b_s, dec_s_s, legal_s;
  logic       cond_ok_s, bubble_s;

  function automatic logic addr_ok(input logic [3:0] addr);
    return (32'(addr) < 32'(REG_COUNT));
  endfunction

  // Status flags are NZCV with N in bit 3; code 1111 never executes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c & !z;
      4'b1001: pass = !c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  assign mode_s    = instruction[27:26];
  assign opcode_s  = instruction[24:21];
  assign imm_s     = instruction[25];
  assign sb_s      = instruction[20];
  assign rd_s      = instruction[15:12];
  assign store_s   = (mode_s == 2'b01) && !sb_s;
  assign src1      = instruction[19:16];
  assign src2      = store_s ? rd_s : instruction[3:0];
  assign two_src   = !imm_s | store_s;
  assign cond_ok_s = cond_pass(instruction[31:28], status);
  assign bubble_s  = flush | stall | !in_valid | !cond_ok_s | !legal_s;

  // Instruction class and opcode decode into execute-stage controls.
  always_comb begin
    cmd_s    = 4'b0000;
    dec_wb_s = 1'b0;
    dec_mr_s = 1'b0;
    dec_mw_s = 1'b0;
    dec_b_s  = 1'b0;
    dec_s_s  = 1'b0;
    legal_s  = 1'b0;
    case (mode_s)
      2'b00: begin
        legal_s  = 1'b1;
        dec_wb_s = 1'b1;
        dec_s_s  = sb_s;
        case (opcode_s)
          4'b1101: cmd_s = 4'b0001;
          4'b1111: cmd_s = 4'b1001;
          4'b0100: cmd_s = 4'b0010;
          4'b0101: cmd_s = 4'b0011;
          4'b0010: cmd_s = 4'b0100;
          4'b0110: cmd_s = 4'b0101;
          4'b0000: cmd_s = 4'b0110;
          4'b1100: cmd_s = 4'b0111;
          4'b0001: cmd_s = 4'b1000;
          4'b1010: begin cmd_s = 4'b0100; dec_wb_s = 1'b0; end
          4'b1000: begin cmd_s = 4'b0110; dec_wb_s = 1'b0; end
          default: begin legal_s = 1'b0; dec_wb_s = 1'b0; dec_s_s = 1'b0; end
        endcase
      end
      2'b01: begin
        legal_s = 1'b1;
        cmd_s   = 4'b0010;
        if (sb_s) begin
          dec_wb_s = 1'b1;
          dec_mr_s = 1'b1;
        end else begin
          dec_mw_s = 1'b1;
        end
      end
      2'b10: begin
        legal_s = 1'b1;
        dec_b_s = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Register file write port; out-of-range destinations are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
    end else if (wb_en && addr_ok(wb_dest)) begin
      regs_r[wb_dest[ADDR_W-1:0]] <= wb_value;
    end
  end

  // Read ports with same-cycle write-back forwarding.
  always_comb begin
    val_rn_s = '0;
    val_rm_s = '0;
    if (wb_en && (wb_dest == src1)) val_rn_s = wb_value;
    else if (addr_ok(src1))         val_rn_s = regs_r[src1[ADDR_W-1:0]];
    else                            val_rn_s = '0;
    if (wb_en && (wb_dest == src2)) val_rm_s = wb_value;
    else if (addr_ok(src2))         val_rm_s = regs_r[src2[ADDR_W-1:0]];
    else                            val_rm_s = '0;
  end

  // ID/EX register: freeze holds, bubbles clear controls but still load datapath fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_mem_r    <= 1'b0;
      ex_mem_w    <= 1'b0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_imm      <= 1'b0;
      ex_exe_cmd  <= 4'b0000;
      ex_pc       <= '0;
      ex_val_rn   <= '0;
      ex_val_rm   <= '0;
      ex_shift_op <= 12'd0;
      ex_imm24    <= 24'd0;
      ex_dest     <= 4'd0;
      ex_src1     <= 4'd0;
      ex_src2     <= 4'd0;
    end else if (!freeze) begin
      ex_valid    <= !bubble_s;
      ex_wb_en    <= dec_wb_s & !bubble_s;
      ex_mem_r    <= dec_mr_s & !bubble_s;
      ex_mem_w    <= dec_mw_s & !bubble_s;
      ex_b        <= dec_b_s & !bubble_s;
      ex_s        <= dec_s_s & !bubble_s;
      ex_exe_cmd  <= bubble_s ? 4'b0000 : cmd_s;
      ex_imm      <= imm_s;
      ex_pc       <= pc_in;
      ex_val_rn   <= val_rn_s;
      ex_val_rm   <= val_rm_s;
      ex_shift_op <= instruction[11:0];
      ex_imm24    <= instruction[23:0];
      ex_dest     <= rd_s;
      ex_src1     <= src1;
      ex_src2     <= src2;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: table-driven reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, stall, in_valid;
  logic [31:0] pc_in, instruction, wb_value;
  logic [3:0]  status, wb_dest;
  logic        wb_en;
  logic        two_src;
  logic [3:0]  src1, src2;
  logic        ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_imm;
  logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_imm24;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  decode_stage_pipe #(.WORD_WIDTH(32), .REG_COUNT(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .stall(stall),
    .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction), .status(status),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .two_src(two_src), .src1(src1), .src2(src2),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm), .ex_exe_cmd(ex_exe_cmd),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
    .ex_shift_op(ex_shift_op), .ex_imm24(ex_imm24),
    .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected ID/EX contents and architectural register file.
  typedef struct {
    logic valid, wb, mr, mw, b, s, imm;
    logic [3:0] cmd, dest, s1, s2;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] i24;
  } ex_t;

  ex_t mdl;
  logic [31:0] mrf [16];
  int cmd_tab [16];

  initial begin
    for (int i = 0; i < 16; i++) cmd_tab[i] = -1;
    cmd_tab[13] = 1;  cmd_tab[15] = 9;  cmd_tab[4] = 2;  cmd_tab[5] = 3;
    cmd_tab[2]  = 4;  cmd_tab[6]  = 5;  cmd_tab[0] = 6;  cmd_tab[12] = 7;
    cmd_tab[1]  = 8;  cmd_tab[10] = 4;  cmd_tab[8] = 6;
  end

  function automatic logic [31:0] mread(input logic [3:0] a);
    return (wb_en && wb_dest == a) ? wb_value : mrf[a];
  endfunction

  function automatic logic [3:0] exp_src2();
    return (instruction[27:26] == 2'b01 && !instruction[20]) ? instruction[15:12] : instruction[3:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl = '{default: '0};
      for (int i = 0; i < 16; i++) mrf[i] = 32'd0;
    end else begin
      if (!freeze) begin
        ex_t nx;
        bit n, z, c, v, legal, good;
        bit ct [16];
        int op, md;
        nx = '{default: '0};
        n = status[3]; z = status[2]; c = status[1]; v = status[0];
        ct = '{z, !z, c, !c, n, !n, v, !v, c && !z, !c || z, n == v, n != v,
               !z && (n == v), z || (n != v), 1'b1, 1'b0};
        md = int'(instruction[27:26]);
        op = int'(instruction[24:21]);
        legal = 1'b1;
        if (md == 0) begin
          legal = (cmd_tab[op] >= 0);
          nx.cmd = 4'(cmd_tab[op]);
          nx.wb = !(op == 10 || op == 8);
          nx.s = instruction[20];
        end else if (md == 1) begin
          nx.cmd = 4'd2;
          nx.wb = instruction[20];
          nx.mr = instruction[20];
          nx.mw = !instruction[20];
        end else if (md == 2) begin
          nx.b = 1'b1;
        end else begin
          legal = 1'b0;
        end
        good = in_valid && ct[instruction[31:28]] && legal && !flush && !stall;
        nx.valid = good;
        if (!good) begin
          nx.cmd = 4'd0; nx.wb = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.b = 1'b0; nx.s = 1'b0;
        end
        nx.imm = instruction[25];
        nx.pc = pc_in;
        nx.s1 = instruction[19:16];
        nx.s2 = exp_src2();
        nx.dest = instruction[15:12];
        nx.rn = mread(nx.s1);
        nx.rm = mread(nx.s2);
        nx.sh = instruction[11:0];
        nx.i24 = instruction[23:0];
        mdl = nx;
      end
      if (wb_en) mrf[wb_dest] = wb_value;
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_valid", 32'(ex_valid), 32'(mdl.valid));
      chk("m_wb_en", 32'(ex_wb_en), 32'(mdl.wb));
      chk("m_mem_r", 32'(ex_mem_r), 32'(mdl.mr));
      chk("m_mem_w", 32'(ex_mem_w), 32'(mdl.mw));
      chk("m_b", 32'(ex_b), 32'(mdl.b));
      chk("m_s", 32'(ex_s), 32'(mdl.s));
      chk("m_exe_cmd", 32'(ex_exe_cmd), 32'(mdl.cmd));
      if (mdl.valid) begin
        chk("m_imm", 32'(ex_imm), 32'(mdl.imm));
        chk("m_pc", ex_pc, mdl.pc);
        chk("m_val_rn", ex_val_rn, mdl.rn);
        chk("m_val_rm", ex_val_rm, mdl.rm);
        chk("m_shift_op", 32'(ex_shift_op), 32'(mdl.sh));
        chk("m_imm24", 32'(ex_imm24), 32'(mdl.i24));
        chk("m_dest", 32'(ex_dest), 32'(mdl.dest));
        chk("m_src1", 32'(ex_src1), 32'(mdl.s1));
        chk("m_src2", 32'(ex_src2), 32'(mdl.s2));
      end
      chk("m_two_src", 32'(two_src), 32'(!instruction[25] || (instruction[27:26] == 2'b01 && !instruction[20])));
      chk("m_src1_comb", 32'(src1), 32'(instruction[19:16]));
      chk("m_src2_comb", 32'(src2), 32'(exp_src2()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] st);
    instruction = ins;
    pc_in = pc;
    status = st;
    in_valid = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [3:0] d, input logic [31:0] v);
    wb_en = en;
    wb_dest = d;
    wb_value = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD_R1_R2_5 = 32'hE282_1005;
  localparam logic [31:0] STR_R3_R4   = 32'hE784_3000;
  localparam logic [31:0] LDR_R3_R4   = 32'hE794_3000;
  localparam logic [31:0] MOV_R0_R5   = 32'hE1A0_0005;
  localparam logic [31:0] BEQ_ABCD    = 32'h0A00_ABCD;
  localparam logic [31:0] CMP_R2_R3   = 32'hE152_0003;

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    pc_in = 32'd0; instruction = 32'd0; status = 4'd0;
    wb(1'b0, 4'd0, 32'd0);
    tick(); tick();
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    chk("reset_cmd", 32'(ex_exe_cmd), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    wb(1'b1, 4'd2, 32'd7);     tick();
    wb(1'b1, 4'd3, 32'hAA);    tick();
    wb(1'b1, 4'd4, 32'h100);   tick();
    wb(1'b0, 4'd0, 32'd0);

    drive(ADD_R1_R2_5, 32'h40, 4'd0);
    #1;
    chk("add_two_src", 32'(two_src), 32'd0);
    tick();
    chk("add_cmd", 32'(ex_exe_cmd), 32'h2);
    chk("add_wb_en", 32'(ex_wb_en), 32'd1);
    chk("add_val_rn", ex_val_rn, 32'd7);
    chk("add_dest", 32'(ex_dest), 32'd1);
    chk("add_imm", 32'(ex_imm), 32'd1);

    drive(STR_R3_R4, 32'h44, 4'd0);
    #1;
    chk("str_src2", 32'(src2), 32'd3);
    chk("str_two_src", 32'(two_src), 32'd1);
    tick();
    chk("str_mem_w", 32'(ex_mem_w), 32'd1);
    chk("str_val_rm", ex_val_rm, 32'hAA);
    chk("str_val_rn", ex_val_rn, 32'h100);
    chk("str_wb_en", 32'(ex_wb_en), 32'd0);

    drive(LDR_R3_R4, 32'h48, 4'd0);
    tick();
    chk("ldr_mem_r", 32'(ex_mem_r), 32'd1);
    chk("ldr_wb_en", 32'(ex_wb_en), 32'd1);

    drive(MOV_R0_R5, 32'h4C, 4'd0);
    wb(1'b1, 4'd5, 32'h1234);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    chk("byp_val_rm", ex_val_rm, 32'h1234);
    chk("mov_cmd", 32'(ex_exe_cmd), 32'h1);

    drive(CMP_R2_R3, 32'h50, 4'd0);
    tick();
    chk("cmp_cmd", 32'(ex_exe_cmd), 32'h4);
    chk("cmp_wb_en", 32'(ex_wb_en), 32'd0);
    chk("cmp_s", 32'(ex_s), 32'd1);

    drive(BEQ_ABCD, 32'h54, 4'b0000);
    tick();
    chk("beq_nz_valid", 32'(ex_valid), 32'd0);
    chk("beq_nz_b", 32'(ex_b), 32'd0);
    drive(BEQ_ABCD, 32'h58, 4'b0100);
    tick();
    chk("beq_z_b", 32'(ex_b), 32'd1);
    chk("beq_z_imm24", 32'(ex_imm24), 32'h00ABCD);
    chk("beq_z_wb", 32'(ex_wb_en), 32'd0);

    drive(ADD_R1_R2_5, 32'h40, 4'd0);
    tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) wb(1'b1, 4'd6, 32'h66);
      else wb(1'b0, 4'd0, 32'd0);
      drive((i == 1) ? STR_R3_R4 : MOV_R0_R5 + 32'(i), 32'h100 + 32'(i), 4'd0);
      tick();
      chk("frz_cmd", 32'(ex_exe_cmd), 32'h2);
      chk("frz_val_rn", ex_val_rn, 32'd7);
      chk("frz_pc", ex_pc, 32'h40);
    end
    freeze = 1'b0;
    flush = 1'b1; stall = 1'b1;
    drive(ADD_R1_R2_5, 32'h60, 4'd0);
    tick();
    chk("fs_valid", 32'(ex_valid), 32'd0);
    chk("fs_wb_en", 32'(ex_wb_en), 32'd0);
    chk("fs_cmd", 32'(ex_exe_cmd), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    freeze = 1'b1; flush = 1'b1;
    drive(STR_R3_R4, 32'h64, 4'd0);
    tick();
    chk("ff_valid", 32'(ex_valid), 32'd1);
    chk("ff_cmd", 32'(ex_exe_cmd), 32'h2);
    chk("ff_mem_w", 32'(ex_mem_w), 32'd0);
    freeze = 1'b0; flush = 1'b0;

    drive(32'hE286_1000, 32'h68, 4'd0);
    tick();
    chk("r6_written", ex_val_rn, 32'h66);

    for (int c = 0; c < 16; c++) begin
      for (int s = 0; s < 8; s++) begin
        logic [3:0] st_tab [8];
        st_tab = '{4'h0, 4'h4, 4'h8, 4'h2, 4'h1, 4'h9, 4'h6, 4'hF};
        drive({4'(c), 28'h282_1005}, 32'(c * 8 + s), st_tab[s]);
        tick();
      end
    end
    for (int op = 0; op < 16; op++) begin
      for (int sb = 0; sb < 2; sb++) begin
        drive({4'hE, 3'b000, 4'(op), 1'(sb), 20'h21003}, 32'(op), 4'd0);
        tick();
      end
    end
    drive(32'hEC00_0000, 32'h70, 4'd0);
    tick();
    chk("mode11_valid", 32'(ex_valid), 32'd0);
    drive(ADD_R1_R2_5, 32'h74, 4'd0);
    in_valid = 1'b0;
    tick();
    chk("inval_valid", 32'(ex_valid), 32'd0);

    drive(ADD_R1_R2_5, 32'h78, 4'd0);
    tick();
    freeze = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_cmd", 32'(ex_exe_cmd), 32'd0);
    chk("rst_val_rn", ex_val_rn, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    tick();
    rst = 1'b0;
    freeze = 1'b0;
    drive(ADD_R1_R2_5, 32'h7C, 4'd0);
    tick();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_rn", ex_val_rn, 32'd0);
    chk("post_rst_pc", ex_pc, 32'h7C);
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
